// File: rtl/lcd1602_pkg.sv
// Shared LCD1602 definitions: opcodes, DDRAM geometry, responder FSM states and
// address helpers used by both the controller and the responder.
package lcd1602_pkg;

  localparam logic [7:0] CLEAR_DISPLAY             = 8'h01;
  localparam logic [7:0] SHIFT_CURSOR_RIGHT        = 8'h06;
  localparam logic [7:0] DISPON_CURSOROFF          = 8'h0C;
  localparam logic [7:0] LINES2_MATRIX5x8_MODE8bit = 8'h38;
  localparam logic [7:0] START_2LINE               = 8'hC0;

  localparam logic [6:0] LINE2_BASE  = 7'h40;
  localparam int         LINE_LEN    = 40;
  localparam int         DDRAM_DEPTH = 80;
  localparam logic [7:0] SPACE       = 8'h20;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_IDLE = 2'd1,
    ST_BUSY = 2'd2
  } lcd_state_e;

  function automatic logic addr_legal(input logic [6:0] a, input logic two);
    if (two) return (a <= 7'h27) || ((a >= LINE2_BASE) && (a <= 7'h67));
    return a <= 7'h4F;
  endfunction

  // Two-line mode hops between the ends of the two 40-byte lines.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc,
                                           input logic two);
    if (two) begin
      if (inc) return (a == 7'h27) ? LINE2_BASE : (a == 7'h67) ? 7'h00 : a + 7'd1;
      return (a == 7'h00) ? 7'h67 : (a == LINE2_BASE) ? 7'h27 : a - 7'd1;
    end
    if (inc) return (a >= 7'h4F) ? 7'h00 : a + 7'd1;
    return (a == 7'h00) ? 7'h4F : a - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 DDRAM: one synchronous write port, one registered read port, and the
// HD44780 address to physical index mapping.
module lcd_ddram
  import lcd1602_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       two_line_i,
  input  logic       we_i,
  input  logic       wr_raw_i,
  input  logic [6:0] wr_addr_i,
  input  logic [7:0] wr_data_i,
  input  logic [6:0] rd_addr_i,
  output logic [7:0] rd_data_o
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] rd_data_q;
  logic [6:0] wr_idx, rd_idx;
  logic       wr_ok, rd_ok;

  function automatic logic [6:0] to_index(input logic [6:0] a, input logic two);
    if (two && (a >= LINE2_BASE)) return a - LINE2_BASE + 7'(LINE_LEN);
    return a;
  endfunction

  // Raw writes address the physical index directly (used by the space fill).
  assign wr_idx = wr_raw_i ? wr_addr_i : to_index(wr_addr_i, two_line_i);
  assign wr_ok  = wr_raw_i ? (wr_addr_i < 7'(DDRAM_DEPTH)) : addr_legal(wr_addr_i, two_line_i);
  assign rd_idx = to_index(rd_addr_i, two_line_i);
  assign rd_ok  = addr_legal(rd_addr_i, two_line_i);

  always_ff @(posedge clk) begin
    if (we_i && wr_ok) mem_q[wr_idx] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_ok ? mem_q[rd_idx] : SPACE;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lcd1602_responder.sv
// HD44780-compatible responder for the 8-bit LCD1602 bus. Define LCD_CGRAM_EN
// to add a 64x5 CGRAM with its own read port.
module lcd1602_responder
  import lcd1602_pkg::*;
#(
  parameter int BUSY_CYCLES  = 1850,
  parameter int CLEAR_CYCLES = 76000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       overrun
`ifdef LCD_CGRAM_EN
  ,
  input  logic [5:0] cg_rd_addr,
  output logic [4:0] cg_rd_data
`endif
);

  localparam int MAXC = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  logic [SYNC_STAGES-1:0][10:0] sync_q;
  logic [10:0] bus_s;
  logic        s_rs, s_rw, s_en, en_prev_q, strobe;
  logic [7:0]  s_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      en_prev_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], {rs, rw, enable, data}};
      en_prev_q <= s_en;
    end
  end

  assign bus_s  = sync_q[SYNC_STAGES-1];
  assign s_rs   = bus_s[10];
  assign s_rw   = bus_s[9];
  assign s_en   = bus_s[8];
  assign s_data = bus_s[7:0];
  assign strobe = en_prev_q & ~s_en & ~s_rw;

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    fill_q, fill_d, cursor_q, cursor_d;
  logic          clr_q, clr_d, inc_q, inc_d, disp_q, disp_d, cur_q, cur_d;
  logic          blink_q, blink_d, two_q, two_d, ovr_q, ovr_d, cgm_q, cgm_d;
  logic          ram_we, ram_raw;
  logic [6:0]    ram_addr;
  logic [7:0]    ram_wdata;
`ifdef LCD_CGRAM_EN
  logic [5:0]    cg_addr_q, cg_addr_d;
  logic          cg_we;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      fill_q   <= '0;
      cursor_q <= '0;
      clr_q    <= 1'b0;
      inc_q    <= 1'b1;
      disp_q   <= 1'b0;
      cur_q    <= 1'b0;
      blink_q  <= 1'b0;
      two_q    <= 1'b0;
      ovr_q    <= 1'b0;
      cgm_q    <= 1'b0;
`ifdef LCD_CGRAM_EN
      cg_addr_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fill_q   <= fill_d;
      cursor_q <= cursor_d;
      clr_q    <= clr_d;
      inc_q    <= inc_d;
      disp_q   <= disp_d;
      cur_q    <= cur_d;
      blink_q  <= blink_d;
      two_q    <= two_d;
      ovr_q    <= ovr_d;
      cgm_q    <= cgm_d;
`ifdef LCD_CGRAM_EN
      cg_addr_q <= cg_addr_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    cursor_d  = cursor_q;
    clr_d     = clr_q;
    inc_d     = inc_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blink_d   = blink_q;
    two_d     = two_q;
    ovr_d     = ovr_q;
    cgm_d     = cgm_q;
    ram_we    = 1'b0;
    ram_raw   = 1'b0;
    ram_addr  = cursor_q;
    ram_wdata = s_data;
`ifdef LCD_CGRAM_EN
    cg_addr_d = cg_addr_q;
    cg_we     = 1'b0;
`endif
    case (state_q)
      ST_FILL: begin
        ram_we    = 1'b1;
        ram_raw   = 1'b1;
        ram_addr  = fill_q;
        ram_wdata = SPACE;
        if (strobe) ovr_d = 1'b1;
        // The clear-display busy count keeps running underneath the fill.
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        if (fill_q == 7'(DDRAM_DEPTH - 1)) begin
          fill_d   = '0;
          cursor_d = '0;
          state_d  = ST_IDLE;
          if (clr_q) begin
            clr_d   = 1'b0;
            inc_d   = 1'b1;
            state_d = (cnt_q > CW'(1)) ? ST_BUSY : ST_IDLE;
          end
        end else begin
          fill_d = fill_q + 7'd1;
        end
      end
      ST_BUSY: begin
        if (strobe) ovr_d = 1'b1;
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_IDLE: begin
        if (strobe) begin
          state_d = ST_BUSY;
          cnt_d   = CW'(BUSY_CYCLES - 1);
          if (s_rs) begin
            if (cgm_q) begin
`ifdef LCD_CGRAM_EN
              cg_we     = 1'b1;
              cg_addr_d = cg_addr_q + 6'd1;
`endif
            end else begin
              ram_we   = 1'b1;
              cursor_d = addr_step(cursor_q, inc_q, two_q);
            end
          end else begin
            casez (s_data)
              8'b1???????: begin
                cursor_d = addr_legal(s_data[6:0], two_q) ? s_data[6:0] : 7'h00;
                cgm_d    = 1'b0;
              end
              8'b01??????: begin
                cgm_d = 1'b1;
`ifdef LCD_CGRAM_EN
                cg_addr_d = s_data[5:0];
`endif
              end
              8'b001?????: two_d = s_data[3];
              8'b0001????: if (!s_data[3]) cursor_d = addr_step(cursor_q, s_data[2], two_q);
              8'b00001???: begin
                disp_d  = s_data[2];
                cur_d   = s_data[1];
                blink_d = s_data[0];
              end
              // Display shift (S) has no visible effect in this model.
              8'b000001??: inc_d = s_data[1];
              8'b0000001?: begin
                cursor_d = '0;
                cnt_d    = CW'(CLEAR_CYCLES - 1);
              end
              8'b00000001: begin
                state_d = ST_FILL;
                fill_d  = '0;
                clr_d   = 1'b1;
                cgm_d   = 1'b0;
                cnt_d   = CW'(CLEAR_CYCLES - 1);
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  lcd_ddram u_ddram (
    .clk       (clk),
    .reset     (reset),
    .two_line_i(two_q),
    .we_i      (ram_we),
    .wr_raw_i  (ram_raw),
    .wr_addr_i (ram_addr),
    .wr_data_i (ram_wdata),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

`ifdef LCD_CGRAM_EN
  logic [4:0] cg_mem_q [64];
  logic [4:0] cg_rd_q;

  always_ff @(posedge clk) begin
    if (cg_we) cg_mem_q[cg_addr_q] <= s_data[4:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cg_rd_q <= '0;
    else        cg_rd_q <= cg_mem_q[cg_rd_addr];
  end

  assign cg_rd_data = cg_rd_q;
`endif

  assign cursor_addr = cursor_q;
  assign display_on  = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign two_line    = two_q;
  assign busy        = (state_q != ST_IDLE);
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed bench for lcd1602_responder: table of bus writes with expected busy
// length, cursor and control bits, plus hand sequences for fill, overrun and CGRAM.
module tb_lcd1602_responder;
  import lcd1602_pkg::*;

  localparam int BC = 20;
  localparam int CC = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rs = 1'b0, rw = 1'b0, enable = 1'b0;
  logic [7:0] data = '0;
  logic [6:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       display_on, cursor_on, blink_on, two_line, busy, overrun;
`ifdef LCD_CGRAM_EN
  logic [5:0] cg_rd_addr = '0;
  logic [4:0] cg_rd_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd1602_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr),
    .display_on(display_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .busy(busy), .overrun(overrun)
`ifdef LCD_CGRAM_EN
    , .cg_rd_addr(cg_rd_addr), .cg_rd_data(cg_rd_data)
`endif
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    int         blen;
    logic [6:0] cur;
    logic [3:0] ctl;  // {two_line, display_on, cursor_on, blink_on}
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  // Full bus write; returns the number of samples busy stayed high (-1 if never).
  task automatic wr(input logic r, input logic [7:0] d, output int blen);
    int t;
    @(negedge clk);
    rs = r; data = d; rw = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    t = 0;
    while (!busy && t < 10) begin @(negedge clk); t++; end
    blen = -1;
    if (busy) begin
      blen = 0;
      while (busy && blen < 1000) begin @(negedge clk); blen++; end
    end
  endtask

  task automatic pulse(input logic r, input logic [7:0] d);
    @(negedge clk);
    rs = r; data = d; rw = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rd(input logic [6:0] a, input logic [7:0] exp);
    rd_addr = a;
    @(negedge clk);
    chk($sformatf("rd_%0h", a), rd_data, exp);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 1000) begin @(negedge clk); t++; end
    chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic addv(input logic r, input logic [7:0] d, input int bl,
                      input logic [6:0] c, input logic [3:0] ct);
    vec_t v;
    v.rs = r; v.d = d; v.blen = bl; v.cur = c; v.ctl = ct;
    vecs.push_back(v);
  endtask

  initial begin
    int n;
    int bl;
    addv(0, 8'h38, BC, 7'h00, 4'h8);
    addv(0, 8'h0C, BC, 7'h00, 4'hC);
    addv(0, 8'h01, CC, 7'h00, 4'hC);
    addv(0, 8'h89, BC, 7'h09, 4'hC);
    addv(1, 8'h46, BC, 7'h0A, 4'hC);
    addv(0, 8'hA7, BC, 7'h27, 4'hC);
    addv(1, 8'h41, BC, 7'h40, 4'hC);
    addv(0, 8'hE7, BC, 7'h67, 4'hC);
    addv(1, 8'h42, BC, 7'h00, 4'hC);
    addv(0, 8'h04, BC, 7'h00, 4'hC);
    addv(1, 8'h43, BC, 7'h67, 4'hC);
    addv(0, 8'h0F, BC, 7'h67, 4'hF);
    addv(0, 8'h14, BC, 7'h00, 4'hF);
    addv(0, 8'h10, BC, 7'h67, 4'hF);
    addv(0, 8'h18, BC, 7'h67, 4'hF);
    addv(0, 8'hB0, BC, 7'h00, 4'hF);
    addv(0, 8'h85, BC, 7'h05, 4'hF);
    addv(0, 8'h02, CC, 7'h00, 4'hF);
    addv(0, 8'h06, BC, 7'h00, 4'hF);
    addv(0, 8'h30, BC, 7'h00, 4'h7);
    addv(0, 8'hC5, BC, 7'h45, 4'h7);
    addv(0, 8'hD0, BC, 7'h00, 4'h7);
    addv(0, 8'h04, BC, 7'h00, 4'h7);
    addv(1, 8'h44, BC, 7'h4F, 4'h7);
    addv(0, 8'hA8, BC, 7'h28, 4'h7);
    addv(0, 8'h06, BC, 7'h28, 4'h7);
    addv(1, 8'h77, BC, 7'h29, 4'h7);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_cursor", cursor_addr, 7'h00);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_ctl", {two_line, display_on, cursor_on, blink_on}, 4'h0);
    chk("rst_rd", rd_data, 8'h00);

    // Release: 80-cycle space fill
    reset = 1'b1;
    n = 0;
    while (busy && n < 200) begin @(negedge clk); n++; end
    chk("fill_len", n, 80);
    chk("fill_cursor", cursor_addr, 7'h00);
    chk("fill_ovr", overrun, 1'b0);
    for (int a = 0; a < 80; a++) rd(7'(a), SPACE);

    for (int i = 0; i < vecs.size(); i++) begin
      wr(vecs[i].rs, vecs[i].d, bl);
      chk($sformatf("v%0d_blen", i), bl, vecs[i].blen);
      chk($sformatf("v%0d_cursor", i), cursor_addr, vecs[i].cur);
      chk($sformatf("v%0d_ctl", i), {two_line, display_on, cursor_on, blink_on}, vecs[i].ctl);
    end

    // One-line readback, then two-line remap of the same storage
    rd(7'h09, 8'h46); rd(7'h27, 8'h41); rd(7'h4F, 8'h42); rd(7'h00, 8'h44);
    rd(7'h28, 8'h77); rd(7'h50, SPACE); rd(7'h0A, SPACE);
    wr(0, 8'h38, bl);
    chk("two_blen", bl, BC);
    rd(7'h67, 8'h42); rd(7'h40, 8'h77); rd(7'h28, SPACE); rd(7'h27, 8'h41);

    // Overrun: second data strobe lands while busy
    chk("ovr_pre", overrun, 1'b0);
    wr(0, 8'h8A, bl);
    chk("ovr_set_blen", bl, BC);
    pulse(1, 8'h61);
    pulse(1, 8'h62);
    rd_addr = 7'h0A;
    @(negedge clk);
    chk("ovr_busy", busy, 1'b1);
    chk("rd_during_busy", rd_data, 8'h61);
    wait_idle();
    chk("ovr_sticky", overrun, 1'b1);
    chk("ovr_cursor", cursor_addr, 7'h0B);
    rd(7'h0B, SPACE);

    // CGRAM / discard mode
    wr(0, 8'h40, bl);
    chk("cg_set_blen", bl, BC);
    for (int i = 0; i < 8; i++) begin
      wr(1, 8'h1F, bl);
      chk($sformatf("cg_wr%0d_blen", i), bl, BC);
    end
    chk("cg_cursor", cursor_addr, 7'h0B);
    rd(7'h0B, SPACE); rd(7'h0C, SPACE); rd(7'h0A, 8'h61);
`ifdef LCD_CGRAM_EN
    for (int i = 0; i < 8; i++) begin
      cg_rd_addr = 6'(i);
      @(negedge clk);
      chk($sformatf("cg_rd%0d", i), cg_rd_data, 5'h1F);
    end
`endif
    wr(0, 8'h80, bl);
    chk("ddram_back", cursor_addr, 7'h00);
    wr(1, 8'h33, bl);
    chk("ddram_back_cur", cursor_addr, 7'h01);
    rd(7'h00, 8'h33);

    // Clear display wipes DDRAM
    wr(0, CLEAR_DISPLAY, bl);
    chk("clr_blen", bl, CC);
    chk("clr_cursor", cursor_addr, 7'h00);
    rd(7'h0A, SPACE); rd(7'h00, SPACE);
    chk("clr_ovr", overrun, 1'b1);

    // Reset again clears overrun
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_ovr", overrun, 1'b0);
    chk("rst2_busy", busy, 1'b1);
    chk("rst2_ctl", {two_line, display_on, cursor_on, blink_on}, 4'h0);
    chk("rst2_cursor", cursor_addr, 7'h00);
    chk("rst2_rd", rd_data, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
